// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: state encodings,
// word width and the default wait-state count.
package dmem_responder_pkg;

  localparam int DMEM_WORD_W         = 32;
  localparam int DEFAULT_WAIT_STATES = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // A word access needs the two byte-offset bits clear.
  function automatic logic is_word_aligned(input logic [1:0] byte_off);
    return byte_off == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with a registered read port.
// The write data is taken from din, and the read data appears on dout on the next clock edge.
module dmem_ram
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [IDX_W-1:0]       idx,
  input  logic [DMEM_WORD_W-1:0] din,
  output logic [DMEM_WORD_W-1:0] dout
);

  logic [DMEM_WORD_W-1:0] mem [DEPTH_WORDS];

  // NOTE: storage arrays get no reset so they map onto RAM macros; contents survive rst.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= din;
    dout <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word load/store per request, inserts
// WAIT_STATES busy cycles, stalls the CPU meanwhile and pulses mem_ready or err.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        stall,
  output logic        err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dmem_state_t            state;
  logic [3:0]             cnt;
  logic                   op_write;
  logic [IDX_W-1:0]       idx_q;
  logic [DMEM_WORD_W-1:0] wdata_q;
  logic [DMEM_WORD_W-1:0] rdata_q;
  logic [DMEM_WORD_W-1:0] ram_dout;

  logic any_req;
  logic valid_req;
  logic reject;
  logic in_range;
  logic ram_we;

  assign any_req   = mem_read | mem_write;
  assign in_range  = addr[31:2] < 30'(DEPTH_WORDS);
  assign valid_req = (mem_read ^ mem_write) && is_word_aligned(addr[1:0]) && in_range;
  assign reject    = any_req && !valid_req;

  // A reset landing on the write edge wins, so an abandoned store never commits.
  assign ram_we = !rst && (state == BUSY) && (cnt == 4'd0) && op_write;

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .idx  (idx_q),
    .din  (wdata_q),
    .dout (ram_dout)
  );

  // NOTE: sequential state uses non-blocking assignments only; always_comb below uses blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rdata_q   <= '0;
      mem_ready <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_req) begin
            op_write <= mem_write;
            idx_q    <= addr[2 +: IDX_W];
            wdata_q  <= wdata;
            cnt      <= 4'(WAIT_STATES);
            state    <= BUSY;
          end else if (reject) begin
            err <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state     <= RESP;
            mem_ready <= 1'b1;
          end
        end
        RESP: begin
          if (!op_write) rdata_q <= ram_dout;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Load data comes straight from the RAM register during RESP, then is held in rdata_q.
  assign rdata = (state == RESP && !op_write) ? ram_dout : rdata_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    stall = valid_req;
        BUSY:    stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with one wait state, one with none.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        mem_read  [2];
  logic        mem_write [2];
  logic [31:0] addr      [2];
  logic [31:0] wdata     [2];
  logic [31:0] rdata     [2];
  logic        mem_ready [2];
  logic        stall     [2];
  logic        err       [2];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_dut0 (
    .clk(clk), .rst(rst[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .mem_ready(mem_ready[0]),
    .stall(stall[0]), .err(err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut1 (
    .clk(clk), .rst(rst[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .mem_ready(mem_ready[1]),
    .stall(stall[1]), .err(err[1])
  );

  int tests_run = 0;
  int failed    = 0;

  typedef struct {
    int          inst;
    bit          is_load;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int ready_at;
    int err_at;
    int stall_cnt;
    bit stall0;
  } obs_t;

  exp_t        sb [$];
  exp_t        mon_e;
  logic [31:0] model [int];

  function automatic int waits(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  // Completion monitor: every mem_ready pops one expected access.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_ready[i] === 1'b1) begin
        tests_run++;
        if (sb.size() == 0) begin
          failed++;
          $display("FAIL sb_unexpected_ready inst%0d: mem_ready=1 with no pending access", i);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.inst != i) begin
            failed++;
            $display("FAIL sb_inst: ready on inst%0d, expected inst%0d", i, mon_e.inst);
          end else if (mon_e.is_load && rdata[i] !== mon_e.data) begin
            failed++;
            $display("FAIL sb_rdata inst%0d: got %h want %h", i, rdata[i], mon_e.data);
          end
        end
      end
    end
  end

  // Drives one request (op 0=read, 1=write, 2=both) and records what the DUT does.
  task automatic access(input int i, input int op, input logic [31:0] a, input logic [31:0] d,
                        input bit mutate, output obs_t o);
    exp_t e;
    @(posedge clk); #1;
    if (op != 2 && a[1:0] == 2'b00 && a[31:2] < DEPTH) begin
      e.inst    = i;
      e.is_load = (op == 0);
      if (op == 1) begin
        model[int'(a[31:2])] = d;
        e.data = d;
      end else begin
        e.data = model.exists(int'(a[31:2])) ? model[int'(a[31:2])] : 32'h0;
      end
      sb.push_back(e);
    end
    mem_read[i]  = (op != 1);
    mem_write[i] = (op != 0);
    addr[i]      = a;
    wdata[i]     = d;
    o.ready_at = -1; o.err_at = -1; o.stall_cnt = 0; o.stall0 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (c == 0) o.stall0 = stall[i];
      if (stall[i] === 1'b1) o.stall_cnt++;
      if (mem_ready[i] === 1'b1) o.ready_at = c;
      if (err[i] === 1'b1) o.err_at = c;
      if (o.ready_at >= 0 || o.err_at >= 0) break;
      @(posedge clk); #1;
      if (mutate && c == 0) begin
        addr[i]  = a + 32'd4;
        wdata[i] = ~d;
      end
    end
    mem_read[i]  = 1'b0;
    mem_write[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst[0] = 1'b1; rst[1] = 1'b1;
    mem_read[0] = 1'b1; addr[0] = 32'h10;
    repeat (3) @(posedge clk);
    #2;
    tests_run++;
    if (stall[0] !== 1'b0) begin
      failed++; $display("FAIL reset_stall: got %b want 0", stall[0]);
    end
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (mem_ready[i] !== 1'b0 || err[i] !== 1'b0 || rdata[i] !== 32'h0) begin
        failed++;
        $display("FAIL reset_outputs inst%0d: ready=%b err=%b rdata=%h want 0/0/0",
                 i, mem_ready[i], err[i], rdata[i]);
      end
    end
    mem_read[0] = 1'b0;
    rst[0] = 1'b0; rst[1] = 1'b0;
  endtask

  task automatic test_store_load();
    obs_t o;
    access(0, 1, 32'h10, 32'hDEADBEEF, 1'b0, o);
    tests_run++;
    if (o.ready_at != 3 || o.stall_cnt != 3 || !o.stall0 || o.err_at >= 0) begin
      failed++;
      $display("FAIL store_timing: ready_at=%0d stall=%0d stall0=%b err_at=%0d want 3/3/1/-1",
               o.ready_at, o.stall_cnt, o.stall0, o.err_at);
    end
    access(0, 0, 32'h10, 32'h0, 1'b0, o);
    tests_run++;
    if (o.ready_at != 3 || o.stall_cnt != 3 || !o.stall0) begin
      failed++;
      $display("FAIL load_timing: ready_at=%0d stall=%0d stall0=%b want 3/3/1",
               o.ready_at, o.stall_cnt, o.stall0);
    end
    @(posedge clk); #2;
    tests_run++;
    if (rdata[0] !== 32'hDEADBEEF || mem_ready[0] !== 1'b0 || stall[0] !== 1'b0) begin
      failed++;
      $display("FAIL rdata_hold: rdata=%h ready=%b stall=%b want deadbeef/0/0",
               rdata[0], mem_ready[0], stall[0]);
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    access(0, 0, 32'h13, 32'h0, 1'b0, o);
    tests_run++;
    if (o.err_at != 1 || o.stall_cnt != 0 || o.ready_at >= 0) begin
      failed++;
      $display("FAIL misaligned_read: err_at=%0d stall=%0d ready_at=%0d want 1/0/-1",
               o.err_at, o.stall_cnt, o.ready_at);
    end
    @(posedge clk); #2;
    tests_run++;
    if (err[0] !== 1'b0) begin
      failed++; $display("FAIL err_pulse_width: err still %b, want 0", err[0]);
    end
    access(0, 1, 32'h11, 32'h0BADF00D, 1'b0, o);
    tests_run++;
    if (o.err_at != 1 || o.stall_cnt != 0) begin
      failed++;
      $display("FAIL misaligned_write: err_at=%0d stall=%0d want 1/0", o.err_at, o.stall_cnt);
    end
    access(0, 0, 32'h10, 32'h0, 1'b0, o);
  endtask

  task automatic test_range_conflict();
    obs_t o;
    access(0, 0, 32'h400, 32'h0, 1'b0, o);
    tests_run++;
    if (o.err_at != 1 || o.stall_cnt != 0 || o.ready_at >= 0) begin
      failed++;
      $display("FAIL out_of_range: err_at=%0d stall=%0d ready_at=%0d want 1/0/-1",
               o.err_at, o.stall_cnt, o.ready_at);
    end
    access(0, 2, 32'h10, 32'h0, 1'b0, o);
    tests_run++;
    if (o.err_at != 1 || o.stall_cnt != 0 || o.ready_at >= 0) begin
      failed++;
      $display("FAIL both_ops: err_at=%0d stall=%0d ready_at=%0d want 1/0/-1",
               o.err_at, o.stall_cnt, o.ready_at);
    end
    access(0, 1, 32'h3FC, 32'hCAFEF00D, 1'b0, o);
    tests_run++;
    if (o.ready_at != 3 || o.err_at >= 0) begin
      failed++;
      $display("FAIL last_word_store: ready_at=%0d err_at=%0d want 3/-1", o.ready_at, o.err_at);
    end
    access(0, 0, 32'h3FC, 32'h0, 1'b0, o);
  endtask

  task automatic test_back_to_back();
    obs_t o;
    access(1, 1, 32'h04, 32'h12345678, 1'b0, o);
    access(1, 0, 32'h04, 32'h0, 1'b0, o);
    tests_run++;
    if (o.ready_at != waits(1) + 2 || o.stall_cnt != 2) begin
      failed++;
      $display("FAIL zero_wait_load: ready_at=%0d stall=%0d want 2/2", o.ready_at, o.stall_cnt);
    end
    access(1, 1, 32'h08, 32'h87654321, 1'b0, o);
    tests_run++;
    if (!o.stall0 || o.ready_at != 2 || o.stall_cnt != 2) begin
      failed++;
      $display("FAIL back_to_back_store: stall0=%b ready_at=%0d stall=%0d want 1/2/2",
               o.stall0, o.ready_at, o.stall_cnt);
    end
    access(1, 0, 32'h08, 32'h0, 1'b0, o);
    access(1, 0, 32'h04, 32'h0, 1'b0, o);
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    access(0, 1, 32'h20, 32'h11111111, 1'b0, o);
    access(0, 0, 32'h20, 32'h0, 1'b0, o);
    @(posedge clk); #1;
    mem_write[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h22222222;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    #1;
    tests_run++;
    if (stall[0] !== 1'b0) begin
      failed++; $display("FAIL stall_in_reset: got %b want 0", stall[0]);
    end
    @(posedge clk); #1;
    rst[0] = 1'b0; mem_write[0] = 1'b0;
    #1;
    tests_run++;
    if (stall[0] !== 1'b0 || rdata[0] !== 32'h0 || mem_ready[0] !== 1'b0) begin
      failed++;
      $display("FAIL after_abort: stall=%b rdata=%h ready=%b want 0/0/0",
               stall[0], rdata[0], mem_ready[0]);
    end
    access(0, 0, 32'h20, 32'h0, 1'b0, o);
    tests_run++;
    if (o.ready_at != 3) begin
      failed++; $display("FAIL reload_after_abort: ready_at=%0d want 3", o.ready_at);
    end
  endtask

  task automatic test_busy_change();
    obs_t o;
    access(0, 1, 32'h34, 32'h55555555, 1'b0, o);
    access(0, 1, 32'h30, 32'hA5A5A5A5, 1'b1, o);
    tests_run++;
    if (o.ready_at != 3 || o.stall_cnt != 3) begin
      failed++;
      $display("FAIL busy_change_timing: ready_at=%0d stall=%0d want 3/3", o.ready_at, o.stall_cnt);
    end
    access(0, 0, 32'h30, 32'h0, 1'b0, o);
    access(0, 0, 32'h34, 32'h0, 1'b0, o);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; mem_read[i] = 1'b0; mem_write[i] = 1'b0;
      addr[i] = 32'h0; wdata[i] = 32'h0;
    end
    test_reset();
    test_store_load();
    test_misaligned();
    test_range_conflict();
    test_back_to_back();
    test_reset_mid_access();
    test_busy_change();
    repeat (4) @(posedge clk);
    #2;
    tests_run++;
    if (sb.size() != 0) begin
      failed++; $display("FAIL sb_drain: %0d accesses never completed, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
